// File: rtl/switch_pio_irq.sv
// switch_pio_irq: debounced switch input port with edge capture, interrupt
// mask and an Avalon-MM slave register interface.
//   addr 0: debounced input value (RO)
//   addr 1: reads zero, writes ignored
//   addr 2: interrupt mask (RW)
//   addr 3: edge capture (read, write-1-to-clear)
module switch_pio_irq #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Counter value at which a persistent difference is accepted.
  localparam logic [15:0] LP_CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;

  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr_en;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  // Bus write qualification; only addresses 2 and 3 have writable state.
  assign w_wr_en = chipselect & ~write_n;
  assign w_clr   = (w_wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

  // Upper writedata bits carry no meaning for narrow ports.
  assign w_unused_wdata = ^writedata;

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce counter and edge qualification.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [15:0] r_cnt;
      logic        w_diff;

      assign w_diff     = r_sync2[gi] ^ r_stable[gi];
      assign w_load[gi] = w_diff & (r_cnt == LP_CNT_LAST);

      // Count cycles of persistent difference; restart on agreement or accept.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else if (!w_diff || w_load[gi]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end

      // The accepted value equals r_sync2, so it tells the edge direction.
      if (EDGE_MODE == 0) begin : g_rise
        assign w_set[gi] = w_load[gi] & r_sync2[gi];
      end else if (EDGE_MODE == 1) begin : g_fall
        assign w_set[gi] = w_load[gi] & ~r_sync2[gi];
      end else begin : g_any
        assign w_set[gi] = w_load[gi];
      end
    end
  endgenerate

  // Debounced value: take the synchronized bit only when its counter expires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '0;
    end else begin
      r_stable <= (r_stable & ~w_load) | (r_sync2 & w_load);
    end
  end

  // Edge capture: sticky, write-1-to-clear, a new edge beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_set;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_wr_en && (address == 2'd2)) begin
      r_mask <= writedata[WIDTH-1:0];
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux[WIDTH-1:0] = r_stable;
      2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
      2'd3:    w_rd_mux[WIDTH-1:0] = r_edge;
      default: w_rd_mux = '0;
    endcase
  end

  // Read data is registered every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rd_mux;
    end
  end

  // Level interrupt built only from registered state.
  assign irq = |(r_edge & r_mask);

endmodule

// File: tb/tb_switch_pio_irq.sv
// Self-checking bench for switch_pio_irq: three instances (rising, falling,
// any edge) share one stimulus; directed sequences plus a register table.
module tb_switch_pio_irq;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int n_checks = 0;
  int n_fail   = 0;

  switch_pio_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  switch_pio_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1));

  switch_pio_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  exp_rd0;
    logic [7:0]  exp_rd1;
    logic [7:0]  exp_rd2;
    logic [2:0]  exp_irq;   // bit0 = u0, bit1 = u1, bit2 = u2
  } bus_vec_t;

  bus_vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_rd(input string name, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2);
    check($sformatf("%s.u0.readdata", name), rd0, {24'd0, e0});
    check($sformatf("%s.u1.readdata", name), rd1, {24'd0, e1});
    check($sformatf("%s.u2.readdata", name), rd2, {24'd0, e2});
  endtask

  task automatic check_irq(input string name, input logic [2:0] e);
    check($sformatf("%s.irq", name), {29'd0, irq2, irq1, irq0}, {29'd0, e});
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    tick();
  endtask

  initial begin
    vecs[0]  = '{2'd0, 1'b0, 32'h0000_0000, 8'hA5, 8'hA5, 8'hA5, 3'b000};
    vecs[1]  = '{2'd1, 1'b0, 32'h0000_0000, 8'h00, 8'h00, 8'h00, 3'b000};
    vecs[2]  = '{2'd1, 1'b1, 32'hFFFF_FFFF, 8'h00, 8'h00, 8'h00, 3'b000};
    vecs[3]  = '{2'd0, 1'b1, 32'h1234_5678, 8'hA5, 8'hA5, 8'hA5, 3'b000};
    vecs[4]  = '{2'd2, 1'b0, 32'h0000_0000, 8'h00, 8'h00, 8'h00, 3'b000};
    vecs[5]  = '{2'd3, 1'b1, 32'hFFFF_FF00, 8'hA5, 8'h00, 8'hA5, 3'b000};
    vecs[6]  = '{2'd2, 1'b1, 32'hFFFF_FF81, 8'h81, 8'h81, 8'h81, 3'b101};
    vecs[7]  = '{2'd3, 1'b1, 32'h0000_0001, 8'hA4, 8'h00, 8'hA4, 3'b101};
    vecs[8]  = '{2'd3, 1'b1, 32'h0000_0080, 8'h24, 8'h00, 8'h24, 3'b000};
    vecs[9]  = '{2'd2, 1'b1, 32'h0000_0001, 8'h01, 8'h01, 8'h01, 3'b000};
    vecs[10] = '{2'd3, 1'b0, 32'h0000_0000, 8'h24, 8'h00, 8'h24, 3'b000};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 8'h00;

    // Reset state
    repeat (3) tick();
    check_rd("in_reset", 8'h00, 8'h00, 8'h00);
    check_irq("in_reset", 3'b000);
    reset_n = 1'b1;
    repeat (3) tick();
    check_rd("after_reset", 8'h00, 8'h00, 8'h00);
    check_irq("after_reset", 3'b000);

    // 0x00 -> 0xA5 accepted exactly 1+D edges after first sample
    in_port = 8'hA5;
    repeat (6) tick();
    check_rd("accept_edge_latency", 8'h00, 8'h00, 8'h00);
    tick();
    check_rd("accept_read", 8'hA5, 8'hA5, 8'hA5);
    bus_read(2'd3);
    check_rd("accept_edgecap", 8'hA5, 8'h00, 8'hA5);

    // Register table
    for (int i = 0; i < 11; i++) begin
      address    = vecs[i].addr;
      writedata  = vecs[i].wdata;
      chipselect = vecs[i].wr;
      write_n    = ~vecs[i].wr;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      tick();
      check_rd($sformatf("vec%0d", i), vecs[i].exp_rd0, vecs[i].exp_rd1, vecs[i].exp_rd2);
      check_irq($sformatf("vec%0d", i), vecs[i].exp_irq);
    end

    // Falling change 0xA5 -> 0x00
    bus_write(2'd3, 32'hFF);
    in_port = 8'h00;
    repeat (8) tick();
    bus_read(2'd3);
    check_rd("fall_edgecap", 8'h00, 8'hA5, 8'hA5);
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3);
    check_rd("clear_all", 8'h00, 8'h00, 8'h00);

    // Glitch: 3 cycles high is rejected (mask is 0x01)
    in_port = 8'h01;
    repeat (3) tick();
    in_port = 8'h00;
    repeat (10) tick();
    bus_read(2'd0);
    check_rd("glitch_stable", 8'h00, 8'h00, 8'h00);
    bus_read(2'd3);
    check_rd("glitch_edgecap", 8'h00, 8'h00, 8'h00);
    check_irq("glitch", 3'b000);

    // Exactly D cycles high is accepted, then the fall follows
    in_port = 8'h01;
    repeat (4) tick();
    in_port = 8'h00;
    repeat (10) tick();
    bus_read(2'd3);
    check_rd("pulse_d_edgecap", 8'h01, 8'h01, 8'h01);
    check_irq("pulse_d", 3'b111);
    bus_write(2'd3, 32'h01);
    check_irq("pulse_d_cleared", 3'b000);

    // irq rises on the accepting edge, clears the cycle after the write
    in_port = 8'h01;
    repeat (5) tick();
    check_irq("irq_before_accept", 3'b000);
    tick();
    check_irq("irq_at_accept", 3'b101);
    bus_write(2'd3, 32'h01);
    check_irq("irq_after_clear", 3'b000);
    in_port = 8'h00;
    repeat (8) tick();
    check_irq("irq_fall", 3'b110);
    bus_write(2'd3, 32'hFF);
    check_irq("irq_fall_cleared", 3'b000);

    // Clear of bit1 on the very edge bit1 is captured: set wins
    in_port = 8'h02;
    repeat (5) tick();
    bus_write(2'd3, 32'h02);
    bus_read(2'd3);
    check_rd("simul_set_wins", 8'h02, 8'h00, 8'h02);
    bus_write(2'd3, 32'h02);
    bus_read(2'd3);
    check_rd("simul_then_clear", 8'h00, 8'h00, 8'h00);

    // 0xFF -> 0x0F: falling and any-edge modes capture 0xF0
    in_port = 8'hFF;
    repeat (8) tick();
    bus_write(2'd3, 32'hFF);
    in_port = 8'h0F;
    repeat (8) tick();
    bus_read(2'd0);
    check_rd("mode_stable", 8'h0F, 8'h0F, 8'h0F);
    bus_read(2'd3);
    check_rd("mode_edgecap", 8'h00, 8'hF0, 8'hF0);

    // Build edgecapture 0x3C with mask 0x3C, then reset mid-debounce
    bus_write(2'd3, 32'hFF);
    in_port = 8'h00;
    repeat (8) tick();
    bus_write(2'd3, 32'hFF);
    in_port = 8'h3C;
    repeat (8) tick();
    bus_write(2'd2, 32'h3C);
    bus_read(2'd3);
    check_rd("pre_reset_edgecap", 8'h3C, 8'h00, 8'h3C);
    check_irq("pre_reset", 3'b101);
    in_port = 8'hFF;
    repeat (2) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_rd("async_reset", 8'h00, 8'h00, 8'h00);
    check_irq("async_reset", 3'b000);
    in_port = 8'h3C;
    repeat (3) tick();
    reset_n = 1'b1;
    bus_read(2'd2);
    check_rd("mask_after_reset", 8'h00, 8'h00, 8'h00);
    bus_read(2'd0);
    check_rd("stable_after_reset", 8'h00, 8'h00, 8'h00);
    repeat (8) tick();
    bus_read(2'd0);
    check_rd("held_high_stable", 8'h3C, 8'h3C, 8'h3C);
    bus_read(2'd3);
    check_rd("held_high_edgecap", 8'h3C, 8'h00, 8'h3C);
    check_irq("held_high", 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
